// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scan / entry slice: digit width, special
// key indices, frame classification and accept-FSM encodings.
package keypad_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_ENTER = 4'd11;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_SINGLE,
    RES_MULTI
  } frame_res_t;

  typedef enum logic {
    ST_IDLE,
    ST_HELD
  } accept_state_t;

endpackage

// File: rtl/keypad_scan_entry_if.sv
// Keypad-facing and lock-facing signals of keypad_scan_entry. The master
// modport is the scanner itself; the slave side is the keypad/lock consumer.
interface keypad_scan_entry_if
#(
  parameter int ROWS   = 3,
  parameter int COLS   = 4,
  parameter int DIGITS = 4
);
  import keypad_pkg::*;

  logic [COLS-1:0]              colin;
  logic [ROWS-1:0]              rowout;
  logic [3:0]                   keycode;
  logic                         keyenbl;
  logic                         key_pulse;
  logic                         enter_pulse;
  logic [DIGIT_W*DIGITS-1:0]    sftreg;
  logic [$clog2(DIGITS+1)-1:0]  count;
  logic                         full;

  modport master (
    input  colin,
    output rowout, keycode, keyenbl, key_pulse, enter_pulse, sftreg, count, full
  );

  modport slave (
    output colin,
    input  rowout, keycode, keyenbl, key_pulse, enter_pulse, sftreg, count, full
  );

endinterface

// File: rtl/keypad_debounce.sv
// Frame-level debounce: a frame result must repeat DEBOUNCE times in a row
// before it is reported, with a strobe on every frame it remains stable.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 2
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       frame_done,
  input  frame_res_t frame_res,
  input  logic [3:0] frame_idx,
  output frame_res_t stable_res,
  output logic [3:0] stable_idx,
  output logic       stable_strobe
);
  localparam int RUN_W = $clog2(DEBOUNCE + 1);

  frame_res_t       last_res;
  logic [3:0]       last_idx;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_next;
  logic             same;

  // The run counter saturates at DEBOUNCE so a long hold keeps strobing.
  assign same     = (frame_res == last_res) && (frame_idx == last_idx);
  assign run_next = !same ? RUN_W'(1)
                  : (run_cnt == RUN_W'(DEBOUNCE)) ? run_cnt
                  : run_cnt + RUN_W'(1);

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      last_res      <= RES_NONE;
      last_idx      <= 4'd0;
      run_cnt       <= '0;
      stable_res    <= RES_NONE;
      stable_idx    <= 4'd0;
      stable_strobe <= 1'b0;
    end else begin
      stable_strobe <= 1'b0;
      if (frame_done) begin
        last_res <= frame_res;
        last_idx <= frame_idx;
        run_cnt  <= run_next;
        if (run_next == RUN_W'(DEBOUNCE)) begin
          stable_strobe <= 1'b1;
          stable_res    <= frame_res;
          stable_idx    <= frame_idx;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scan_entry.sv
// Keypad front end: one-hot row scan, per-frame key classification, debounced
// accept FSM and a BCD entry buffer feeding the lock comparator.
module keypad_scan_entry
  import keypad_pkg::*;
#(
  parameter int ROWS     = 3,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 64,
  parameter int DEBOUNCE = 2,
  parameter int DIGITS   = 4
) (
  input logic                 ck,
  input logic                 reset,
  keypad_scan_entry_if.master bus
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int BUF_W = DIGIT_W * DIGITS;

  logic [COLS-1:0]  col_meta, col_sync;
  logic [DIV_W-1:0] div_cnt;
  logic [ROW_W-1:0] row_idx;
  logic             dwell_end, frame_end;

  logic [1:0]       row_hits, acc_hits, tot_hits;
  logic [2:0]       hit_sum;
  logic [COL_W-1:0] row_col;
  logic [3:0]       row_key, acc_idx, next_idx;
  frame_res_t       res_now, frame_res;
  logic [3:0]       frame_idx;
  logic             frame_done;

  frame_res_t       stable_res;
  logic [3:0]       stable_idx;
  logic             stable_strobe;

  accept_state_t    state, state_next;
  logic             key_pulse, enter_pulse;
  logic [3:0]       keycode;
  logic [BUF_W-1:0] sftreg;
  logic [CNT_W-1:0] count;
  logic             full;

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      col_meta <= '0;
      col_sync <= '0;
    end else begin
      col_meta <= bus.colin;
      col_sync <= col_meta;
    end
  end

  assign dwell_end = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_end = dwell_end && (row_idx == ROW_W'(ROWS - 1));

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      row_idx <= '0;
    end else if (dwell_end) begin
      div_cnt <= '0;
      row_idx <= frame_end ? '0 : row_idx + ROW_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign bus.rowout = ROWS'(1) << row_idx;

  // Hit count saturates at 2: all the frame result needs is none/one/many.
  always_comb begin
    row_hits = 2'd0;
    row_col  = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (col_sync[c]) begin
        row_col = COL_W'(c);
        if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
      end
    end
  end

  assign row_key  = 4'(row_idx * COLS) + 4'(row_col);
  assign hit_sum  = {1'b0, acc_hits} + {1'b0, row_hits};
  assign tot_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
  assign next_idx = (acc_hits == 2'd0) ? row_key : acc_idx;

  always_comb begin
    res_now = RES_MULTI;
    if (tot_hits == 2'd0)      res_now = RES_NONE;
    else if (tot_hits == 2'd1) res_now = RES_SINGLE;
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      acc_hits   <= 2'd0;
      acc_idx    <= 4'd0;
      frame_res  <= RES_NONE;
      frame_idx  <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_end) begin
        acc_hits   <= 2'd0;
        acc_idx    <= 4'd0;
        frame_res  <= res_now;
        frame_idx  <= (tot_hits == 2'd1) ? next_idx : 4'd0;
        frame_done <= 1'b1;
      end else if (dwell_end) begin
        acc_hits <= tot_hits;
        acc_idx  <= next_idx;
      end
    end
  end

  keypad_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .ck            (ck),
    .reset         (reset),
    .frame_done    (frame_done),
    .frame_res     (frame_res),
    .frame_idx     (frame_idx),
    .stable_res    (stable_res),
    .stable_idx    (stable_idx),
    .stable_strobe (stable_strobe)
  );

  always_ff @(posedge ck or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // A different key while held is ignored; MULTI never moves the FSM.
  always_comb begin
    state_next = state;
    if (stable_strobe) begin
      case (state)
        ST_IDLE: if (stable_res == RES_SINGLE) state_next = ST_HELD;
        ST_HELD: if (stable_res == RES_NONE)   state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    key_pulse   = stable_strobe && (state == ST_IDLE) && (stable_res == RES_SINGLE);
    enter_pulse = key_pulse && (stable_idx == KEY_ENTER);
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset)          keycode <= 4'd0;
    else if (key_pulse) keycode <= stable_idx;
  end

  // ENTER clears on the edge closing its pulse, so the lock sees the digits first.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      sftreg <= '0;
      count  <= '0;
    end else if (key_pulse) begin
      if (stable_idx < 4'd10) begin
        if (!full) begin
          sftreg <= (sftreg << DIGIT_W) | BUF_W'(stable_idx);
          count  <= count + CNT_W'(1);
        end
      end else if (stable_idx == KEY_CLEAR || stable_idx == KEY_ENTER) begin
        sftreg <= '0;
        count  <= '0;
      end
    end
  end

  assign full = (count == CNT_W'(DIGITS));

  assign bus.keycode     = keycode;
  assign bus.keyenbl     = (state == ST_HELD);
  assign bus.key_pulse   = key_pulse;
  assign bus.enter_pulse = enter_pulse;
  assign bus.sftreg      = sftreg;
  assign bus.count       = count;
  assign bus.full        = full;

endmodule

// File: tb/tb_keypad_scan_entry.sv
// Self-checking bench for keypad_scan_entry: a frame-level keypad/lock model
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_keypad_scan_entry;
  localparam int ROWS     = 3;
  localparam int COLS     = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int DIGITS   = 4;
  localparam int FRAME    = ROWS * SCAN_DIV;
  localparam int ACC_LAT  = 2;

  logic ck = 1'b0;
  logic reset = 1'b1;
  logic [15:0] pressed = 16'h0000;

  int vectors = 0;
  int miscompares = 0;

  int t;
  int last_kind, last_idx, run;
  bit m_held, m_enbl;
  int m_keycode;
  int mq[$];
  bit ev_valid, ev_accept;
  int ev_time, ev_idx;

  int pulses_seen = 0;
  int enters_seen = 0;
  int enter_sft = 0;

  keypad_scan_entry_if #(.ROWS(ROWS), .COLS(COLS), .DIGITS(DIGITS)) kbus ();

  keypad_scan_entry #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .DIGITS(DIGITS)
  ) dut (
    .ck    (ck),
    .reset (reset),
    .bus   (kbus)
  );

  always #5 ck = ~ck;

  // Physical keypad: a pressed key connects its row drive to its column.
  always_comb begin
    kbus.colin = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (kbus.rowout[r] && pressed[r*COLS + c]) kbus.colin[c] = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic int modelBuffer();
    int v = 0;
    foreach (mq[i]) v = (v << 4) | mq[i];
    return v;
  endfunction

  task automatic modelReset();
    t = 0; last_kind = 0; last_idx = 0; run = 0;
    m_held = 0; m_enbl = 0; m_keycode = 0;
    mq.delete();
    ev_valid = 0; ev_accept = 0; ev_time = 0; ev_idx = 0;
  endtask

  // Frame-level model: classify the held key set, count repeats, and schedule
  // the visible accept/release a fixed latency after the frame ends.
  task automatic modelFrameEnd();
    int n = 0, k = 0, kind, kidx;
    for (int i = 0; i < ROWS*COLS; i++) if (pressed[i]) begin n++; k = i; end
    kind = (n == 0) ? 0 : (n == 1) ? 1 : 2;
    kidx = (n == 1) ? k : 0;
    run = (kind == last_kind && kidx == last_idx) ? run + 1 : 1;
    last_kind = kind;
    last_idx  = kidx;
    if (run >= DEBOUNCE) begin
      if (!m_held && kind == 1) begin
        m_held = 1; ev_valid = 1; ev_accept = 1; ev_time = t + ACC_LAT; ev_idx = kidx;
      end else if (m_held && kind == 0) begin
        m_held = 0; ev_valid = 1; ev_accept = 0; ev_time = t + ACC_LAT;
      end
    end
  endtask

  always @(negedge ck) begin
    logic [ROWS-1:0] exp_row;
    bit ev_now, exp_kp, exp_ep;
    if (reset) begin
      modelReset();
    end else begin
      exp_row = ROWS'(1) << ((t / SCAN_DIV) % ROWS);
      ev_now  = ev_valid && (ev_time == t);
      exp_kp  = ev_now && ev_accept;
      exp_ep  = exp_kp && (ev_idx == 11);
      checkOutput("rowout",      32'(kbus.rowout),      32'(exp_row));
      checkOutput("key_pulse",   32'(kbus.key_pulse),   32'(exp_kp));
      checkOutput("enter_pulse", 32'(kbus.enter_pulse), 32'(exp_ep));
      checkOutput("keycode",     32'(kbus.keycode),     32'(m_keycode));
      checkOutput("keyenbl",     32'(kbus.keyenbl),     32'(m_enbl));
      checkOutput("sftreg",      32'(kbus.sftreg),      32'(modelBuffer()));
      checkOutput("count",       32'(kbus.count),       32'(mq.size()));
      checkOutput("full",        32'(kbus.full),        32'(mq.size() == DIGITS));
      if (kbus.key_pulse) pulses_seen++;
      if (kbus.enter_pulse) begin
        enters_seen++;
        enter_sft = 32'(kbus.sftreg);
      end
      if (ev_now) begin
        ev_valid = 0;
        if (ev_accept) begin
          m_keycode = ev_idx;
          m_enbl = 1;
          if (ev_idx < 10) begin
            if (mq.size() < DIGITS) mq.push_back(ev_idx);
          end else if (ev_idx == 10 || ev_idx == 11) begin
            mq.delete();
          end
        end else begin
          m_enbl = 0;
        end
      end
      if (t % FRAME == FRAME - 1) modelFrameEnd();
      t++;
    end
  end

  task automatic applyStimulus(input logic [15:0] mask, input int frames);
    pressed = mask;
    repeat (frames * FRAME) @(posedge ck);
    #1;
  endtask

  task automatic pressKey(input int idx);
    applyStimulus(16'(1 << idx), 2);
    applyStimulus(16'h0000, 2);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(posedge ck);
    #1 reset = 1'b0;
  endtask

  initial begin
    int p0, e0;
    $display("[TB] keypad_scan_entry bench start");

    // Scenario 1: reset values, free-running scan, async reset mid-row.
    repeat (2) @(posedge ck);
    #1;
    checkOutput("rst_rowout",  32'(kbus.rowout),    32'h1);
    checkOutput("rst_keycode", 32'(kbus.keycode),   32'h0);
    checkOutput("rst_keyenbl", 32'(kbus.keyenbl),   32'h0);
    checkOutput("rst_pulse",   32'(kbus.key_pulse), 32'h0);
    checkOutput("rst_sftreg",  32'(kbus.sftreg),    32'h0);
    checkOutput("rst_count",   32'(kbus.count),     32'h0);
    checkOutput("rst_full",    32'(kbus.full),      32'h0);
    reset = 1'b0;
    applyStimulus(16'h0000, 3);
    repeat (5) @(posedge ck);
    #1;
    checkOutput("midrow_rowout", 32'(kbus.rowout), 32'h2);
    reset = 1'b1;
    #1;
    checkOutput("async_rowout", 32'(kbus.rowout), 32'h1);
    @(posedge ck);
    #1 reset = 1'b0;

    // Scenario 2: key 5 held three frames, then released.
    p0 = pulses_seen;
    applyStimulus(16'(1 << 5), 3);
    checkOutput("s2_pulses",  32'(pulses_seen - p0), 32'd1);
    checkOutput("s2_keycode", 32'(kbus.keycode),     32'd5);
    checkOutput("s2_keyenbl", 32'(kbus.keyenbl),     32'd1);
    checkOutput("s2_sftreg",  32'(kbus.sftreg),      32'h0005);
    checkOutput("s2_count",   32'(kbus.count),       32'd1);
    applyStimulus(16'h0000, 3);
    checkOutput("s2_rel_keyenbl", 32'(kbus.keyenbl), 32'd0);
    checkOutput("s2_rel_keycode", 32'(kbus.keycode), 32'd5);

    // Scenario 3: one-frame bounce, then a two-key ghost held four frames.
    p0 = pulses_seen;
    applyStimulus(16'(1 << 2), 1);
    applyStimulus(16'h0000, 2);
    checkOutput("s3_bounce_pulses", 32'(pulses_seen - p0), 32'd0);
    applyStimulus(16'((1 << 1) | (1 << 6)), 4);
    checkOutput("s3_multi_pulses",  32'(pulses_seen - p0), 32'd0);
    checkOutput("s3_multi_keyenbl", 32'(kbus.keyenbl),     32'd0);
    checkOutput("s3_multi_keycode", 32'(kbus.keycode),     32'd5);
    applyStimulus(16'h0000, 2);

    // Scenario 4: fill the buffer, then overflow with a fifth digit.
    doReset();
    checkOutput("s4_rst_sftreg", 32'(kbus.sftreg), 32'h0);
    for (int d = 1; d <= 4; d++) pressKey(d);
    checkOutput("s4_sftreg", 32'(kbus.sftreg), 32'h1234);
    checkOutput("s4_count",  32'(kbus.count),  32'd4);
    checkOutput("s4_full",   32'(kbus.full),   32'd1);
    p0 = pulses_seen;
    pressKey(5);
    checkOutput("s4_over_pulses",  32'(pulses_seen - p0), 32'd1);
    checkOutput("s4_over_keycode", 32'(kbus.keycode),     32'd5);
    checkOutput("s4_over_sftreg",  32'(kbus.sftreg),      32'h1234);
    checkOutput("s4_over_count",   32'(kbus.count),       32'd4);

    // Scenario 5: ENTER presents the digits, then the buffer empties.
    e0 = enters_seen;
    pressKey(11);
    checkOutput("s5_enters",    32'(enters_seen - e0), 32'd1);
    checkOutput("s5_enter_sft", 32'(enter_sft),        32'h1234);
    checkOutput("s5_sftreg",    32'(kbus.sftreg),      32'h0);
    checkOutput("s5_count",     32'(kbus.count),       32'd0);
    checkOutput("s5_full",      32'(kbus.full),        32'd0);

    // Scenario 6: two digits then CLEAR.
    e0 = enters_seen;
    pressKey(7);
    pressKey(8);
    checkOutput("s6_sftreg78", 32'(kbus.sftreg), 32'h0078);
    checkOutput("s6_count2",   32'(kbus.count),  32'd2);
    pressKey(10);
    checkOutput("s6_clr_sftreg",  32'(kbus.sftreg),      32'h0);
    checkOutput("s6_clr_count",   32'(kbus.count),       32'd0);
    checkOutput("s6_clr_full",    32'(kbus.full),        32'd0);
    checkOutput("s6_clr_keycode", 32'(kbus.keycode),     32'd10);
    checkOutput("s6_clr_enters",  32'(enters_seen - e0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
